// File: rtl/imsic_csr_seq.sv
// rtl/imsic_csr_seq.sv - round-robin sequencer for IMSIC indirect CSR accesses
// Optional WAIT timeout compiled in with IMSIC_CSR_SEQ_TIMEOUT_EN.
module imsic_csr_seq #(
    parameter int NR_REQ          = 2,
    parameter int XLEN            = 64,
    parameter int NR_INTP_FILES   = 7,
    parameter int INTP_FILE_WIDTH = 3,
    parameter int TIMEOUT_CYC     = 15
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NR_REQ-1:0]          req_vld,
    output logic [NR_REQ-1:0]          req_rdy,
    input  logic [NR_REQ*12-1:0]       req_addr,
    input  logic [NR_REQ*2-1:0]        req_priv,
    input  logic [NR_REQ-1:0]          req_v,
    input  logic [NR_REQ*6-1:0]        req_vgein,
    input  logic [NR_REQ-1:0]          req_wdata_vld,
    input  logic [NR_REQ*2-1:0]        req_wdata_op,
    input  logic [NR_REQ*XLEN-1:0]     req_wdata,
    output logic [NR_REQ-1:0]          rsp_vld,
    output logic [XLEN-1:0]            rsp_rdata,
    output logic                       rsp_illegal,
    output logic [11:0]                csr_addr,
    output logic                       csr_rd,
    output logic [INTP_FILE_WIDTH-1:0] intp_file_sel,
    output logic                       priv_is_illegal,
    output logic                       csr_v,
    output logic                       csr_wdata_vld,
    output logic [1:0]                 csr_wdata_op,
    output logic [XLEN-1:0]            csr_wdata,
    input  logic                       csr_rdata_vld,
    input  logic [XLEN-1:0]            csr_rdata,
    input  logic                       csr_illegal
);
    localparam int GW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                     state_q, state_d;
    logic [GW-1:0]              last_q, last_d;
    logic [11:0]                addr_q, addr_d;
    logic                       rd_q, rd_d;
    logic [INTP_FILE_WIDTH-1:0] file_q, file_d;
    logic                       illegal_q, illegal_d;
    logic                       v_q, v_d;
    logic                       wvld_q, wvld_d;
    logic [1:0]                 wop_q, wop_d;
    logic [XLEN-1:0]            wdata_q, wdata_d;
    logic [NR_REQ-1:0]          rsp_vld_q, rsp_vld_d;
    logic [XLEN-1:0]            rsp_rdata_q, rsp_rdata_d;
    logic                       rsp_illegal_q, rsp_illegal_d;
`ifdef IMSIC_CSR_SEQ_TIMEOUT_EN
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYC - 1);
    logic [3:0]                 to_cnt_q, to_cnt_d;
`endif

    logic                       win_found;
    logic [GW-1:0]              win_idx;
    logic [11:0]                win_addr;
    logic [1:0]                 win_priv;
    logic                       win_v;
    logic [5:0]                 win_vgein;
    logic                       win_wvld;
    logic [1:0]                 win_wop;
    logic [XLEN-1:0]            win_wdata;
    logic                       dec_illegal;
    logic [INTP_FILE_WIDTH-1:0] dec_file;

    // Pass 0 scans requesters above last_grant, pass 1 wraps around from 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_addr  = '0;
        win_priv  = '0;
        win_v     = 1'b0;
        win_vgein = '0;
        win_wvld  = 1'b0;
        win_wop   = '0;
        win_wdata = '0;
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < NR_REQ; j++) begin
                if (!win_found && req_vld[j] && ((p == 0) == (j > int'(last_q)))) begin
                    win_found = 1'b1;
                    win_idx   = GW'(j);
                    win_addr  = req_addr[j*12 +: 12];
                    win_priv  = req_priv[j*2 +: 2];
                    win_v     = req_v[j];
                    win_vgein = req_vgein[j*6 +: 6];
                    win_wvld  = req_wdata_vld[j];
                    win_wop   = req_wdata_op[j*2 +: 2];
                    win_wdata = req_wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        dec_illegal = (win_priv != 2'b11 && win_priv != 2'b01) ||
                      (win_v && (win_priv == 2'b11 || win_vgein == 6'd0 ||
                                 int'(win_vgein) > NR_INTP_FILES - 2));
        if (dec_illegal) begin
            dec_file = '0;
        end else if (win_v) begin
            dec_file = INTP_FILE_WIDTH'(int'(win_vgein) + 1);
        end else if (win_priv == 2'b11) begin
            dec_file = '0;
        end else begin
            dec_file = INTP_FILE_WIDTH'(1);
        end
    end

    // Grant follows req_vld combinationally; held low while reset is asserted.
    assign req_rdy = (rstn && state_q == IDLE && win_found) ? (NR_REQ'(1) << win_idx) : '0;

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        addr_d        = addr_q;
        rd_d          = 1'b0;
        file_d        = file_q;
        illegal_d     = illegal_q;
        v_d           = v_q;
        wvld_d        = wvld_q;
        wop_d         = wop_q;
        wdata_d       = wdata_q;
        rsp_vld_d     = '0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_illegal_d = rsp_illegal_q;
`ifdef IMSIC_CSR_SEQ_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d   = ISSUE;
                    last_d    = win_idx;
                    addr_d    = win_addr;
                    rd_d      = 1'b1;
                    file_d    = dec_file;
                    illegal_d = dec_illegal;
                    v_d       = win_v;
                    wvld_d    = win_wvld;
                    wop_d     = win_wop;
                    wdata_d   = win_wdata;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef IMSIC_CSR_SEQ_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (csr_rdata_vld) begin
                    state_d       = RESP;
                    wvld_d        = 1'b0;
                    rsp_vld_d     = NR_REQ'(1) << last_q;
                    rsp_rdata_d   = csr_rdata;
                    rsp_illegal_d = csr_illegal;
`ifdef IMSIC_CSR_SEQ_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    state_d       = RESP;
                    wvld_d        = 1'b0;
                    rsp_vld_d     = NR_REQ'(1) << last_q;
                    rsp_rdata_d   = '0;
                    rsp_illegal_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 4'd1;
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            last_q        <= GW'(NR_REQ - 1);
            addr_q        <= '0;
            rd_q          <= 1'b0;
            file_q        <= '0;
            illegal_q     <= 1'b0;
            v_q           <= 1'b0;
            wvld_q        <= 1'b0;
            wop_q         <= '0;
            wdata_q       <= '0;
            rsp_vld_q     <= '0;
            rsp_rdata_q   <= '0;
            rsp_illegal_q <= 1'b0;
`ifdef IMSIC_CSR_SEQ_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            addr_q        <= addr_d;
            rd_q          <= rd_d;
            file_q        <= file_d;
            illegal_q     <= illegal_d;
            v_q           <= v_d;
            wvld_q        <= wvld_d;
            wop_q         <= wop_d;
            wdata_q       <= wdata_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_illegal_q <= rsp_illegal_d;
`ifdef IMSIC_CSR_SEQ_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
`endif
        end
    end

    assign csr_addr        = addr_q;
    assign csr_rd          = rd_q;
    assign intp_file_sel   = file_q;
    assign priv_is_illegal = illegal_q;
    assign csr_v           = v_q;
    assign csr_wdata_vld   = wvld_q;
    assign csr_wdata_op    = wop_q;
    assign csr_wdata       = wdata_q;
    assign rsp_vld         = rsp_vld_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_illegal     = rsp_illegal_q;

endmodule

// File: doc/imsic_csr_seq.md
# imsic_csr_seq

Sequencer and round-robin arbiter in front of the IMSIC interrupt-file register block. It accepts indirect CSR accesses (miselect/mireg, siselect/sireg, vsiselect/vsireg) from up to NR_REQ requesters over valid/ready handshakes. It grants one access at a time and translates the requester's privilege, virtualization and VGEIN into an interrupt-file select and an illegal-privilege flag. It issues a single-cycle read/write strobe to the register block, waits for its read-valid, and returns data and illegal status to the granted requester.

## Interface
- NR_REQ, 2, number of requesters (1..8)
- XLEN, 64, CSR data width (32 or 64)
- NR_INTP_FILES, 7, interrupt files: M, S, then NR_INTP_FILES-2 guest files
- INTP_FILE_WIDTH, 3, width of file select; must hold NR_INTP_FILES-1
- TIMEOUT_CYC, 15, WAIT-state timeout in cycles; used only with the macro (4-bit counter)

Ports (clock and reset first):
- clk  in  1  single clock
- rstn  in  1  asynchronous active-low reset
- req_vld  in  NR_REQ  access request, one bit per requester
- req_rdy  out  NR_REQ  request accepted when vld&rdy
- req_addr  in  NR_REQ*12  iselect offset per requester
- req_priv  in  NR_REQ*2  privilege per requester: 11=M, 01=S, others illegal
- req_v  in  NR_REQ  virtualization mode
- req_vgein  in  NR_REQ*6  guest file index (hstatus.VGEIN)
- req_wdata_vld  in  NR_REQ  access carries a write
- req_wdata_op  in  NR_REQ*2  01 RW, 10 set, 11 clear, 00 illegal
- req_wdata  in  NR_REQ*XLEN  write data
- rsp_vld  out  NR_REQ  one-cycle response strobe to the granted requester
- rsp_rdata  out  XLEN  response read data, shared
- rsp_illegal  out  1  response illegal flag, shared
- csr_addr  out  12  to register block
- csr_rd  out  1  one-cycle access strobe
- intp_file_sel  out  INTP_FILE_WIDTH  selected file
- priv_is_illegal  out  1  privilege check failed
- csr_v  out  1  virtualization mode
- csr_wdata_vld  out  1  write qualifier
- csr_wdata_op  out  2  write op
- csr_wdata  out  XLEN  write data
- csr_rdata_vld  in  1  register block read valid
- csr_rdata  in  XLEN  register block read data
- csr_illegal  in  1  register block illegal, valid with csr_rdata_vld

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - req_rdy is 1 only for the round-robin winner among req_vld bits; all other bits are 0.
  - Round-robin search starts at last_grant+1 modulo NR_REQ. last_grant resets to NR_REQ-1, so requester 0 wins first.
  - On handshake: latch all fields of the winner, update last_grant, go to ISSUE.
- File select, computed at latch time:
  - priv=11, v=0 -> file 0.
  - priv=01, v=0 -> file 1.
  - v=1 -> file 1+vgein.
- priv_is_illegal is 1 when any of these holds:
  - priv is 00 or 10;
  - v=1 and priv=11;
  - v=1 and vgein=0;
  - v=1 and vgein>NR_INTP_FILES-2.
  - When illegal, intp_file_sel is forced to 0.
- ISSUE: csr_rd=1 for exactly one cycle, with all csr_* outputs from the latch. Go to WAIT.
- WAIT: hold the csr_* outputs (csr_rd=0). On csr_rdata_vld, capture csr_rdata and csr_illegal, then go to RESP.
- RESP:
  - rsp_vld[granted]=1 for one cycle, driving the captured rsp_rdata and rsp_illegal. Go to IDLE.
- Illegal accesses are still issued. The register block produces the illegal response, and rsp_illegal reflects csr_illegal.
- A requester holds req_vld and its fields until req_rdy. Requester fields may change after the handshake.
- Outputs when not driving a transaction:
  - csr_rd, csr_wdata_vld and rsp_vld are 0 outside their states.
  - The other csr_* outputs keep their last value.
  - rsp_rdata and rsp_illegal hold until the next RESP.

## Timing
- Reset values of all outputs are 0: req_rdy, rsp_vld, rsp_rdata, rsp_illegal, and all csr_* outputs.
- Asynchronous reset mid-transaction: return to IDLE with no response emitted. last_grant returns to NR_REQ-1.
- Latency, handshake at cycle T:
  - csr_rd at T+1;
  - csr_rdata_vld expected at T+2;
  - rsp_vld at T+3.
- Maximum throughput is one access per 4 cycles. The next handshake can occur in the cycle after RESP.
- csr_rdata_vld outside WAIT is ignored.
- When req_vld changes in IDLE, the grant tracks it combinationally. There is no request buffering.

## Configuration
- Macro IMSIC_CSR_SEQ_TIMEOUT_EN, compiled in:
  - A 4-bit counter clears on entering WAIT and increments every WAIT cycle.
  - If it reaches TIMEOUT_CYC without csr_rdata_vld, go to RESP with rsp_rdata=0 and rsp_illegal=1.
- Compiled out: no counter; WAIT waits indefinitely.

## Test plan
- Single M read of addr 0x70 from req0 (priv=11, v=0):
  - csr_rd=1 at T+1 with intp_file_sel=0 and priv_is_illegal=0.
  - Register block returns rdata=1 at T+2.
  - rsp_vld[0]=1 at T+3 with rsp_rdata=1 and rsp_illegal=0.
- req0 and req1 held valid continuously: grants alternate 0,1,0,1. Each rsp_vld goes only to the matching requester, 4 cycles apart.
- VS write from req1 (v=1, priv=01, vgein=3, op=10, wdata=0x4, addr 0xC0): csr_wdata_vld=1, csr_wdata_op=10, intp_file_sel=4, priv_is_illegal=0.
- v=1 with vgein=0, and separately vgein=6 with NR_INTP_FILES=7: priv_is_illegal=1 and intp_file_sel=0. Register block returns illegal=1, so rsp_illegal=1.
- Assert rstn low during WAIT: all outputs are 0 immediately and no rsp_vld follows. The next request from req0 is granted first.
- With IMSIC_CSR_SEQ_TIMEOUT_EN and TIMEOUT_CYC=15, never assert csr_rdata_vld: rsp_vld arrives 15 WAIT cycles after entering WAIT, with rsp_rdata=0 and rsp_illegal=1.
